// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the Rx bit sampling path.
// Used by rx_bit_sampler and its vote sub-block.
package uart_rx_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int MIN_DIVISOR = 4;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_sample_vote.sv
// Captures three samples around a bit midpoint and votes them.
// Enables come from the parent's counter matches.
module rx_sample_vote
  import uart_rx_pkg::*;
#(
  parameter int MAJORITY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en0_i,
  input  logic en1_i,
  input  logic en2_i,
  input  logic rx_i,
  output logic vote_o
);

  logic s0_q;
  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      if (en0_i) s0_q <= rx_i;
      if (en1_i) s1_q <= rx_i;
      if (en2_i) s2_q <= rx_i;
    end
  end

  assign vote_o = (MAJORITY != 0) ? maj3(s0_q, s1_q, s2_q)
                                  : s2_q;

endmodule

// File: rtl/rx_bit_sampler.sv
// Per-frame bit-period timer and sampling strobe for the UART Rx.
// Idles between frames; divisor latched on each accepted start.
module rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FRAME_BITS = 10,
  parameter int MAJORITY   = 1,
  parameter int IDX_W      = $clog2(FRAME_BITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_detected,
  input  logic             rx_sync,
  input  logic [DIV_W-1:0] divisor,
  output logic             sample_strobe,
  output logic             sampled_bit,
  output logic [IDX_W-1:0] bit_index,
  output logic             frame_done,
  output logic             framing_error,
  output logic             false_start,
  output logic             divisor_error
);

  state_e           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] idx_q;
  logic             strobe_q;
  logic             div_err_q;

  logic active;
  logic load;
  logic hit0;
  logic hit1;
  logic hit2;
  logic first_bit;
  logic last_bit;
  logic stop;
  logic vote;

  assign active    = (state_q == ACTIVE);
  assign hit2      = active && (cnt_q == div_q - DIV_W'(1));
  assign hit1      = active && (cnt_q == div_q - DIV_W'(2));
  assign hit0      = active && (cnt_q == div_q - DIV_W'(3));
  assign cnt_d     = hit2 ? '0 : cnt_q + DIV_W'(1);
  assign load      = !active && start_detected
                  && (divisor >= DIV_W'(MIN_DIVISOR));
  assign first_bit = (idx_q == '0);
  assign last_bit  = (idx_q == IDX_W'(FRAME_BITS - 1));
  assign stop      = strobe_q && ((first_bit && vote) || last_bit);

  rx_sample_vote #(
    .MAJORITY(MAJORITY)
  ) u_vote (
    .clk     (clk),
    .reset   (reset),
    .clear_i (load),
    .en0_i   (hit0),
    .en1_i   (hit1),
    .en2_i   (hit2),
    .rx_i    (rx_sync),
    .vote_o  (vote)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      strobe_q  <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      strobe_q  <= 1'b0;
      div_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (load) begin
            div_q   <= divisor;
            // first wrap lands half a bit after the start edge
            cnt_q   <= (divisor >> 1) + DIV_W'(1);
            idx_q   <= '0;
            state_q <= ACTIVE;
          end else if (start_detected) begin
            div_err_q <= 1'b1;
          end
        end
        ACTIVE: begin
          cnt_q    <= cnt_d;
          strobe_q <= hit2;
          if (strobe_q) idx_q <= idx_q + IDX_W'(1);
          if (stop) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_strobe = strobe_q;
  assign sampled_bit   = strobe_q & vote;
  assign bit_index     = idx_q;
  assign frame_done    = strobe_q & last_bit;
  assign framing_error = strobe_q & last_bit & ~vote;
  assign false_start   = strobe_q & first_bit & vote;
  assign divisor_error = div_err_q;

`ifdef FORMAL
  logic [DIV_W-1:0] gap_q;
  logic             seen_q;
  logic             prev_stb_q;

  always_ff @(posedge clk) begin
    prev_stb_q <= reset ? 1'b0 : strobe_q;
    if (reset || !active) begin
      gap_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      gap_q <= strobe_q ? DIV_W'(1) : gap_q + DIV_W'(1);
      if (strobe_q) seen_q <= 1'b1;
    end
    if (!reset) begin
      if (active) assert (cnt_q < div_q);
      assert (!(strobe_q && prev_stb_q));
      if (active && strobe_q && seen_q) assert (gap_q == div_q);
    end
  end
`endif

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Bench for rx_bit_sampler: majority and single-sample instances
// against a cycle-indexed frame model.
module tb_rx_bit_sampler;

  localparam int DIV_W = 16;
  localparam int FB    = 10;
  localparam int IW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset          = 1'b1;
  logic             start_detected = 1'b0;
  logic             rx_sync        = 1'b1;
  logic [DIV_W-1:0] divisor        = 16'd8;

  logic          stb[2];
  logic          sb[2];
  logic [IW-1:0] bi[2];
  logic          fd[2];
  logic          fe[2];
  logic          fs[2];
  logic          de[2];

  rx_bit_sampler #(
    .DIV_W(DIV_W), .FRAME_BITS(FB), .MAJORITY(1)
  ) u_maj (
    .clk            (clk),
    .reset          (reset),
    .start_detected (start_detected),
    .rx_sync        (rx_sync),
    .divisor        (divisor),
    .sample_strobe  (stb[1]),
    .sampled_bit    (sb[1]),
    .bit_index      (bi[1]),
    .frame_done     (fd[1]),
    .framing_error  (fe[1]),
    .false_start    (fs[1]),
    .divisor_error  (de[1])
  );

  rx_bit_sampler #(
    .DIV_W(DIV_W), .FRAME_BITS(FB), .MAJORITY(0)
  ) u_one (
    .clk            (clk),
    .reset          (reset),
    .start_detected (start_detected),
    .rx_sync        (rx_sync),
    .divisor        (divisor),
    .sample_strobe  (stb[0]),
    .sampled_bit    (sb[0]),
    .bit_index      (bi[0]),
    .frame_done     (fd[0]),
    .framing_error  (fe[0]),
    .false_start    (fs[0]),
    .divisor_error  (de[0])
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tmark    = 0;

  logic rxh[0:131071];
  bit   act[2];
  int   t0[2];
  int   dq[2];
  bit   derr[2];

  int   off1[$];
  logic b1[$];
  int   ix1[$];
  logic b0[$];

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, a, e);
    end
  endtask

  function automatic logic samp(int m, int c);
    return (c > t0[m]) ? rxh[c] : 1'b0;
  endfunction

  function automatic int strobe_k(int m, int c);
    int r;
    if (!act[m]) return -1;
    r = c - t0[m] - (dq[m] - dq[m] / 2);
    if (r < 0 || (r % dq[m]) != 0) return -1;
    return r / dq[m];
  endfunction

  function automatic logic vote(int m, int c);
    int ones;
    ones = int'(samp(m, c - 3)) + int'(samp(m, c - 2))
         + int'(samp(m, c - 1));
    return (m == 1) ? (ones >= 2) : samp(m, c - 1);
  endfunction

  function automatic int at_i(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int at_l(input logic q[$], input int i);
    return (i < q.size()) ? int'(q[i]) : -1;
  endfunction

  task automatic step();
    @(negedge clk);
    rxh[cyc] = rx_sync;
    for (int m = 0; m < 2; m++) begin
      int k;
      logic v;
      logic [9:0] ev;
      logic [9:0] av;
      k  = strobe_k(m, cyc);
      v  = (k >= 0) ? vote(m, cyc) : 1'b0;
      ev = {k >= 0, v, (k >= 0) ? 4'(k) : 4'd0,
            k == FB - 1, (k == FB - 1) && !v, (k == 0) && v,
            derr[m]};
      av = {stb[m], sb[m], stb[m] ? bi[m] : 4'd0,
            fd[m], fe[m], fs[m], de[m]};
      if (cyc > 0)
        chk($sformatf("cyc%0d_inst%0d", cyc, m), int'(av), int'(ev));
    end
    if (stb[1]) begin
      off1.push_back(cyc - tmark);
      b1.push_back(sb[1]);
      ix1.push_back(int'(bi[1]));
    end
    if (stb[0]) b0.push_back(sb[0]);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      int k;
      bit was;
      bit term;
      k    = strobe_k(m, cyc);
      was  = act[m];
      term = (k == FB - 1) || (k == 0 && vote(m, cyc));
      if (reset) begin
        act[m]  = 1'b0;
        derr[m] = 1'b0;
      end else begin
        derr[m] = !was && start_detected && (divisor < 4);
        if (was && term) begin
          act[m] = 1'b0;
        end else if (!was && start_detected && divisor >= 4) begin
          act[m] = 1'b1;
          t0[m]  = cyc;
          dq[m]  = int'(divisor);
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic frame(
    input int d, input logic [9:0] bits,
    input int gl_bit, input int gl_cnt, input int eb,
    input int chg_r, input int chg_v, input int rb, input int gap
  );
    int off;
    int n;
    int k;
    off = d - d / 2;
    n   = off + 9 * d + 2 + gap;
    tmark = cyc;
    off1.delete();
    b1.delete();
    ix1.delete();
    b0.delete();
    for (int r = 0; r < n; r++) begin
      k = (r <= off) ? 0 : (r - off + d - 1) / d;
      if (k > 9) k = 9;
      rx_sync = bits[k];
      if (gl_bit >= 0 && r == off + gl_bit * d - d + gl_cnt)
        rx_sync = ~rx_sync;
      start_detected = (r == 0)
                    || (eb >= 0 && r == off + eb * d - d / 2);
      divisor = (chg_r >= 0 && r >= chg_r) ? 16'(chg_v) : 16'(d);
      reset   = (rb >= 0 && r == off + rb * d - 2);
      step();
    end
    start_detected = 1'b0;
    reset          = 1'b0;
  endtask

  initial begin
    act  = '{0, 0};
    derr = '{0, 0};
    t0   = '{0, 0};
    dq   = '{1, 1};
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) step();
    chk("reset_state", int'({stb[1], sb[1], bi[1], fd[1],
                             fe[1], fs[1], de[1]}), 0);
    reset = 1'b0;
    repeat (2) step();

    frame(8, 10'b1010101010, -1, 0, -1, -1, 0, -1, 4);
    chk("nom_count", off1.size(), 10);
    for (int k = 0; k < off1.size(); k++) begin
      chk($sformatf("nom_time%0d", k), at_i(off1, k), 4 + 8 * k);
      chk($sformatf("nom_bit%0d", k), at_l(b1, k), k % 2);
      chk($sformatf("nom_idx%0d", k), at_i(ix1, k), k);
    end

    frame(16, 10'b1000010000, 4, 13, -1, -1, 0, -1, 4);
    chk("glitch13_maj", at_l(b1, 4), 1);
    chk("glitch13_one", at_l(b0, 4), 1);
    frame(16, 10'b1000010000, 4, 15, -1, -1, 0, -1, 4);
    chk("glitch15_maj", at_l(b1, 4), 1);
    chk("glitch15_one", at_l(b0, 4), 0);

    frame(8, 10'b1111111111, -1, 0, -1, -1, 0, -1, 4);
    chk("false_start_count", off1.size(), 1);
    chk("false_start_bit", at_l(b1, 0), 1);
    frame(8, 10'b0111111110, -1, 0, -1, -1, 0, -1, 4);
    chk("framing_idx", at_i(ix1, 9), 9);
    chk("framing_bit", at_l(b1, 9), 0);

    frame(3, 10'b1111111110, -1, 0, -1, -1, 0, -1, 4);
    chk("div3_strobes", off1.size(), 0);
    frame(4, 10'b1000000001, -1, 0, -1, 3, 20, -1, 4);
    chk("div4_first", at_i(off1, 0), 2);
    chk("div4_bit0", at_l(b1, 0), 0);
    chk("div4_count", off1.size(), 10);
    chk("div4_last", at_i(off1, 9), 38);
    chk("div4_single_fs", b0.size(), 1);

    frame(8, 10'b1010101010, -1, 0, -1, -1, 0, 5, 4);
    chk("reset_mid_count", off1.size(), 5);
    frame(8, 10'b1010101010, -1, 0, -1, -1, 0, -1, 4);
    chk("after_reset_idx0", at_i(ix1, 0), 0);
    chk("after_reset_count", off1.size(), 10);

    frame(8, 10'b1010101010, -1, 0, 4, -1, 0, -1, 4);
    chk("ign_start_count", off1.size(), 10);
    chk("ign_start_last", at_i(off1, 9), 76);
    chk("ign_start_idx5", at_i(ix1, 5), 5);

    for (int f = 0; f < 120; f++) begin
      int d;
      int eb;
      int rb;
      logic [9:0] bits;
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3))
                                      : int'($urandom_range(4, 24));
      bits = 10'($urandom);
      if ($urandom_range(0, 7) != 0) bits[0] = 1'b0;
      if ($urandom_range(0, 3) != 0) bits[9] = 1'b1;
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
      rb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 9)) : -1;
      frame(d, bits, int'($urandom_range(0, 9)),
            int'($urandom_range(0, d - 1)), eb,
            int'($urandom_range(1, 4 * d)),
            int'($urandom_range(0, 65535)), rb,
            int'($urandom_range(1, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_bit_sampler.md
Name: rx_bit_sampler

Overview:
Parametrised successor to the fixed-rate Rx sampling strobe generator.
- Takes a runtime-programmable clocks-per-bit divisor and latches it per frame.
- Takes a 3-sample majority vote around each bit midpoint.
- Tracks bit position within a frame and flags false starts and framing errors.
- Sits between the Rx start-bit detector and the Rx shift register. The counter idles between frames instead of free-running.

Parameters:
DIV_W, 16, width of divisor port and internal bit-period counter
FRAME_BITS, 10, bits per frame including start and stop bits (start + 8 data + 1 stop)
MAJORITY, 1, 1 = 3-sample majority vote; 0 = single sample at the last count
IDX_W, $clog2(FRAME_BITS), width of bit_index

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_detected  in  1  one-cycle pulse from the start detector
rx_sync  in  1  synchronised serial input
divisor  in  DIV_W  clocks per UART bit; sampled only on an accepted start
sample_strobe  out  1  one-cycle pulse: sampled_bit/bit_index valid
sampled_bit  out  1  voted bit value
bit_index  out  IDX_W  position of sampled bit (0 = start bit)
frame_done  out  1  pulse with strobe of the last bit
framing_error  out  1  pulse with frame_done when the stop bit is 0
false_start  out  1  pulse with strobe of bit 0 when the start bit is 1
divisor_error  out  1  pulse when start_detected arrives with divisor < 4

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high: the port is named reset and sampled on the rising edge of clk.
- Reset state: all outputs 0, FSM IDLE, counter 0, index 0, sample regs 0. Reset mid-frame returns to IDLE next cycle with no pulses.
- FSM states are IDLE and ACTIVE.
- IDLE:
  - Counter held at 0.
  - On start_detected with divisor >= 4: latch div_q = divisor, load counter = (divisor>>1)+1, clear s0/s1/s2 to 0, set idx to 0, go ACTIVE.
  - On start_detected with divisor < 4: divisor_error = 1 for one cycle, stay IDLE.
- ACTIVE counter: increments each cycle and wraps div_q-1 -> 0. Divisor port changes are ignored until the next frame.
- ACTIVE sampling: s0 is captured at count div_q-3, s1 at div_q-2, s2 at div_q-1. Samples that do not occur after the load keep their cleared value 0.
- Strobe timing:
  - Strobe is registered: sample_strobe = 1 in the cycle after counter == div_q-1.
  - sampled_bit = maj(s0,s1,s2) if MAJORITY=1, else s2. bit_index = idx. idx increments after each strobe.
  - For start_detected at cycle T, strobes occur at T + D - (D>>1) + k*D for k = 0..FRAME_BITS-1.
- idx==0 and sampled_bit==1: false_start = 1 with the strobe, return to IDLE.
- idx==FRAME_BITS-1: frame_done = 1 with the strobe, framing_error = !sampled_bit, return to IDLE. In the cycle after frame_done the counter is 0.
- start_detected while ACTIVE is ignored (no resync).
- start_detected in the same cycle as the return to IDLE is ignored. The start detector must not re-fire within the stop bit.
- sample_strobe is never high on two consecutive cycles. All pulse outputs are exactly one cycle wide.
- Counter stays < div_q at all times.
- Widths: counter is DIV_W bits, compared against div_q-1 with no overflow (divisor >= 4 guaranteed). Divisor values up to 2^DIV_W-1 are supported.

Decomposition:
- Shared package uart_rx_pkg holds:
  - state enum {IDLE, ACTIVE}
  - constant MIN_DIVISOR = 4
  - function maj3(a,b,c)
- Optional sub-module rx_sample_vote: holds s0/s1/s2 capture and the vote, driven by counter-match enables from the parent. Everything else stays in rx_bit_sampler.
- Formal properties are kept under `ifdef FORMAL`:
  - counter < div_q
  - no back-to-back strobes
  - strobe spacing == div_q while ACTIVE

Test Plan:
1. Nominal frame: divisor=8, start_detected at T, rx stream 0,1,0,1,0,1,0,1,0,1 -> strobes at T+4, T+12, ..., T+76; sampled_bit follows the stream; bit_index 0..9; frame_done at T+76; no errors.
2. Glitch rejection: divisor=16, MAJORITY=1, single-cycle inversion of rx at count 13 of data bit 3 -> sampled_bit unchanged. With MAJORITY=0 and the glitch at count 15 -> bit flips.
3. False start and framing: rx=1 at the bit-0 sample point -> false_start with the first strobe, IDLE next cycle, no further strobes. A separate frame with stop bit 0 -> frame_done and framing_error together at index 9.
4. Divisor limits: divisor=3 -> divisor_error pulse, no strobes. Divisor=4 -> first strobe at T+2 with voted value from s2 only (s0, s1 = 0). Divisor changed to 20 mid-frame -> spacing stays 4.
5. Reset mid-frame: reset asserted at bit 5 -> next cycle all outputs 0, FSM IDLE. A new start_detected -> fresh frame from index 0.
6. Ignored start: start_detected pulsed at bit 4 -> strobe timing and index unaffected.
